// File: rtl/param_cpu.sv
// param_cpu: multi-cycle IDLE/DECODE/EXEC/MEM/WB processor with a small register file and data memory.
// Define PARAM_CPU_SAT_EN to clamp ADD/ADDI/SUB results on overflow/borrow instead of wrapping.
module param_cpu #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_BITS   = 5,
    parameter int REG_BITS    = 2,
    parameter int INSTR_WIDTH = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    output logic                   done,
    input  logic [REG_BITS-1:0]    dbg_sel,
    output logic [DATA_WIDTH-1:0]  dbg_data,
    output logic                   zero_flag,
    output logic                   carry_flag
);

    localparam int NUM_REGS = 2 ** REG_BITS;
    localparam int DEPTH    = 2 ** ADDR_BITS;
    localparam int OP_LSB   = INSTR_WIDTH - 3;
    localparam int X1_LSB   = OP_LSB - REG_BITS;
    localparam int X2_LSB   = X1_LSB - REG_BITS;
    localparam int X3_LSB   = X2_LSB - REG_BITS;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_LOAD  = 3'd2;
    localparam logic [2:0] OP_STORE = 3'd3;
    localparam logic [2:0] OP_AND   = 3'd4;
    localparam logic [2:0] OP_OR    = 3'd5;
    localparam logic [2:0] OP_ADDI  = 3'd6;
    localparam logic [2:0] OP_NOP   = 3'd7;

    typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;

    state_t                r_state;
    logic [2:0]            r_op;
    logic [REG_BITS-1:0]   r_x1, r_x2, r_x3;
    logic [ADDR_BITS-1:0]  r_imm;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] r_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] r_result;
    logic [DATA_WIDTH-1:0] r_storeData;
    logic                  r_carry;

    logic [DATA_WIDTH-1:0] w_a, w_b, w_immExt;
    logic [DATA_WIDTH:0]   w_sum, w_diff, w_sumImm;
    logic [DATA_WIDTH-1:0] w_aluResult;
    logic                  w_aluCarry;
    logic [ADDR_BITS-1:0]  w_addr;
    logic                  w_isAluOp;
    logic                  w_unused;

    // Only the decoded fields matter; the remaining instruction bits are don't-care.
    assign w_unused  = ^instruction;
    assign dbg_data  = r_regs[dbg_sel];
    assign w_a       = r_regs[r_x2];
    assign w_b       = r_regs[r_x3];
    assign w_immExt  = DATA_WIDTH'(r_imm);
    assign w_sum     = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff    = {1'b0, w_a} - {1'b0, w_b};
    assign w_sumImm  = {1'b0, w_a} + {1'b0, w_immExt};
    assign w_addr    = ADDR_BITS'(w_a) + r_imm;
    assign w_isAluOp = r_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI};

    always_comb begin
        w_aluResult = '0;
        w_aluCarry  = 1'b0;
        case (r_op)
`ifdef PARAM_CPU_SAT_EN
            OP_ADD:  begin
                w_aluResult = w_sum[DATA_WIDTH] ? '1 : w_sum[DATA_WIDTH-1:0];
                w_aluCarry  = w_sum[DATA_WIDTH];
            end
            OP_SUB:  begin
                w_aluResult = w_diff[DATA_WIDTH] ? '0 : w_diff[DATA_WIDTH-1:0];
                w_aluCarry  = w_diff[DATA_WIDTH];
            end
            OP_ADDI: begin
                w_aluResult = w_sumImm[DATA_WIDTH] ? '1 : w_sumImm[DATA_WIDTH-1:0];
                w_aluCarry  = w_sumImm[DATA_WIDTH];
            end
`else
            OP_ADD:  begin
                w_aluResult = w_sum[DATA_WIDTH-1:0];
                w_aluCarry  = w_sum[DATA_WIDTH];
            end
            OP_SUB:  begin
                w_aluResult = w_diff[DATA_WIDTH-1:0];
                w_aluCarry  = w_diff[DATA_WIDTH];
            end
            OP_ADDI: begin
                w_aluResult = w_sumImm[DATA_WIDTH-1:0];
                w_aluCarry  = w_sumImm[DATA_WIDTH];
            end
`endif
            OP_AND:  w_aluResult = w_a & w_b;
            OP_OR:   w_aluResult = w_a | w_b;
            default: w_aluResult = '0;
        endcase
    end

    // Architectural writes happen only on the edge leaving the done-pulse state,
    // so a reset mid-instruction leaves no partial update behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            instr_ready <= 1'b1;
            done        <= 1'b0;
            zero_flag   <= 1'b0;
            carry_flag  <= 1'b0;
            r_op        <= OP_NOP;
            r_x1        <= '0;
            r_x2        <= '0;
            r_x3        <= '0;
            r_imm       <= '0;
            r_addr      <= '0;
            r_result    <= '0;
            r_storeData <= '0;
            r_carry     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= DATA_WIDTH'(i);
            for (int i = 0; i < DEPTH; i++)    r_mem[i]  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (instr_valid) begin
                        r_op        <= instruction[OP_LSB +: 3];
                        r_x1        <= instruction[X1_LSB +: REG_BITS];
                        r_x2        <= instruction[X2_LSB +: REG_BITS];
                        r_x3        <= instruction[X3_LSB +: REG_BITS];
                        r_imm       <= instruction[ADDR_BITS-1:0];
                        instr_ready <= 1'b0;
                        r_state     <= DECODE;
                    end
                end
                DECODE: r_state <= EXEC;
                EXEC: begin
                    r_result    <= w_aluResult;
                    r_carry     <= w_aluCarry;
                    r_addr      <= w_addr;
                    r_storeData <= r_regs[r_x1];
                    if (r_op == OP_LOAD || r_op == OP_STORE) begin
                        done    <= (r_op == OP_STORE);
                        r_state <= MEM;
                    end else begin
                        done    <= 1'b1;
                        r_state <= WB;
                    end
                end
                MEM: begin
                    if (r_op == OP_STORE) begin
                        r_mem[r_addr] <= r_storeData;
                        done          <= 1'b0;
                        instr_ready   <= 1'b1;
                        r_state       <= IDLE;
                    end else begin
                        r_result <= r_mem[r_addr];
                        done     <= 1'b1;
                        r_state  <= WB;
                    end
                end
                WB: begin
                    if (w_isAluOp) begin
                        r_regs[r_x1] <= r_result;
                        zero_flag    <= (r_result == '0);
                        carry_flag   <= r_carry;
                    end else if (r_op == OP_LOAD) begin
                        r_regs[r_x1] <= r_result;
                    end
                    done        <= 1'b0;
                    instr_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    done        <= 1'b0;
                    instr_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_cpu.sv
// tb_param_cpu: randomized scoreboard bench for param_cpu against an arithmetic reference model.
// Honours PARAM_CPU_SAT_EN in the model when the design is built with it.
module tb_param_cpu;

    localparam int DW    = 8;
    localparam int AB    = 5;
    localparam int RB    = 2;
    localparam int IW    = 20;
    localparam int NREGS = 4;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] instruction;
    logic          instr_valid;
    logic          instr_ready;
    logic          done;
    logic [RB-1:0] dbg_sel;
    logic [DW-1:0] dbg_data;
    logic          zero_flag;
    logic          carry_flag;

    param_cpu #(
        .DATA_WIDTH (DW),
        .ADDR_BITS  (AB),
        .REG_BITS   (RB),
        .INSTR_WIDTH(IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .done       (done),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int acceptCnt;
        int latency;
        int regIdx;
        int regVal;
        bit zf;
        bit cf;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cycleCnt = 0;
    int   lastAccept = 0;
    bit   dumpReq = 1'b0;
    exp_t expQ[$];
    int   mRegs[NREGS];
    int   mMem[DEPTH];
    bit   mZ, mC;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [IW-1:0] mk(input int op, input int x1, input int x2,
                                         input int x3, input int imm, input int pad);
        logic [IW-1:0] w;
        w        = '0;
        w[19:17] = op[2:0];
        w[16:15] = x1[1:0];
        w[14:13] = x2[1:0];
        w[12:11] = x3[1:0];
        w[10:5]  = pad[5:0];
        w[4:0]   = imm[4:0];
        return w;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NREGS; i++) mRegs[i] = i;
        for (int i = 0; i < DEPTH; i++) mMem[i] = 0;
        mZ = 1'b0;
        mC = 1'b0;
    endtask

    // Reference semantics in plain integer arithmetic; pushes the expected outcome.
    task automatic modelIssue(input logic [IW-1:0] ins, input int acc);
        int   op, x1, x2, x3, imm, a, b, r;
        exp_t e;
        op  = int'(ins[19:17]);
        x1  = int'(ins[16:15]);
        x2  = int'(ins[14:13]);
        x3  = int'(ins[12:11]);
        imm = int'(ins[4:0]);
        a   = mRegs[x2];
        b   = mRegs[x3];
        case (op)
            0, 6: begin
                r  = (op == 0) ? a + b : a + imm;
                mC = (r > 255);
`ifdef PARAM_CPU_SAT_EN
                if (r > 255) r = 255;
`endif
                mRegs[x1] = r % 256;
                mZ        = (mRegs[x1] == 0);
            end
            1: begin
                r  = a - b;
                mC = (r < 0);
`ifdef PARAM_CPU_SAT_EN
                if (r < 0) r = 0;
`endif
                mRegs[x1] = (r + 256) % 256;
                mZ        = (mRegs[x1] == 0);
            end
            2: mRegs[x1] = mMem[(a + imm) % DEPTH];
            3: mMem[(a + imm) % DEPTH] = mRegs[x1];
            4, 5: begin
                mRegs[x1] = (op == 4) ? (a & b) : (a | b);
                mC        = 1'b0;
                mZ        = (mRegs[x1] == 0);
            end
            default: ;
        endcase
        e.acceptCnt = acc;
        e.latency   = (op == 2) ? 4 : 3;
        e.regIdx    = x1;
        e.regVal    = mRegs[x1];
        e.zf        = mZ;
        e.cf        = mC;
        expQ.push_back(e);
    endtask

    // Called on a falling edge; returns on the falling edge after the accept edge.
    task automatic applyStimulus(input logic [IW-1:0] ins, input bit keepValid, output int waited);
        waited = 0;
        while (instr_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (instr_ready !== 1'b1) begin
            checkOutput("readyTimeout", int'(instr_ready), 1);
            return;
        end
        instruction = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lastAccept = cycleCnt;
        modelIssue(ins, cycleCnt);
        checkOutput("readyAfterAccept", int'(instr_ready), 0);
        if (!keepValid) instr_valid = 1'b0;
    endtask

    task automatic requestDump();
        dumpReq = 1'b1;
        for (int k = 0; k < 10 && dumpReq; k++) @(negedge clk);
        if (dumpReq) begin
            checkOutput("dumpTimeout", int'(dumpReq), 0);
            dumpReq = 1'b0;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && expQ.size() > 0; k++) @(negedge clk);
        if (expQ.size() > 0) begin
            checkOutput("drainTimeout", expQ.size(), 0);
            expQ.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: pops an expectation on every done pulse and checks the committed state.
    initial begin
        exp_t e;
        dbg_sel = '0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedDone", int'(done), 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("doneLatency", cycleCnt - e.acceptCnt + 1, e.latency);
                    @(negedge clk);
                    checkOutput("donePulse", int'(done), 0);
                    dbg_sel = RB'(e.regIdx);
                    #1;
                    checkOutput("regWrite", int'(dbg_data), e.regVal);
                    checkOutput("zeroFlag", int'(zero_flag), int'(e.zf));
                    checkOutput("carryFlag", int'(carry_flag), int'(e.cf));
                end
            end
            if (dumpReq) begin
                for (int i = 0; i < NREGS; i++) begin
                    dbg_sel = RB'(i);
                    #1;
                    checkOutput("regDump", int'(dbg_data), mRegs[i]);
                end
                dumpReq = 1'b0;
            end
        end
    end

    initial begin
        int waited, accA, releaseCnt, op;
        rst         = 1'b0;
        instr_valid = 1'b0;
        instruction = '0;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("resetReady", int'(instr_ready), 1);
        checkOutput("resetDone", int'(done), 0);
        checkOutput("resetZero", int'(zero_flag), 0);
        checkOutput("resetCarry", int'(carry_flag), 0);
        requestDump();
        rst = 1'b1;

        applyStimulus(mk(0, 0, 1, 3, 0, 0), 1'b0, waited);
        applyStimulus(mk(1, 3, 1, 2, 0, 0), 1'b0, waited);
        applyStimulus(mk(3, 1, 2, 0, 15, 0), 1'b0, waited);
        applyStimulus(mk(2, 3, 2, 0, 15, 0), 1'b0, waited);
        drain();

        // Valid held high across two instructions: the second waits for IDLE.
        applyStimulus(mk(0, 2, 2, 2, 0, 0), 1'b1, waited);
        accA = lastAccept;
        applyStimulus(mk(5, 1, 0, 2, 0, 0), 1'b0, waited);
        checkOutput("holdNotReadyCycles", waited, 3);
        checkOutput("holdAcceptGap", lastAccept - accA, 4);
        drain();

        // Reset while a LOAD sits in MEM.
        applyStimulus(mk(2, 0, 1, 0, 3, 0), 1'b0, waited);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        expQ.delete();
        modelReset();
        repeat (2) begin
            @(negedge clk);
            checkOutput("abortDone", int'(done), 0);
            checkOutput("abortReady", int'(instr_ready), 1);
        end
        requestDump();
        releaseCnt = cycleCnt;
        rst = 1'b1;
        applyStimulus(mk(0, 0, 3, 3, 0, 0), 1'b0, waited);
        checkOutput("firstEdgeAccept", lastAccept - releaseCnt, 1);
        applyStimulus(mk(3, 0, 3, 0, 31, 0), 1'b0, waited);
        applyStimulus(mk(2, 1, 2, 0, 0, 0), 1'b0, waited);
        applyStimulus(mk(7, 1, 0, 0, 9, 0), 1'b0, waited);
        drain();
        requestDump();

        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 7));
            applyStimulus(mk(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                             int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
                             int'($urandom_range(0, 63))),
                          bit'($urandom_range(0, 1)), waited);
        end
        instr_valid = 1'b0;
        drain();
        requestDump();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
